icsp_nibble_tx: RTL and testbench
=================================

Name: icsp_nibble_tx

Overview:
Downstream serializer for the PIC programmer datapath. It consumes the 4-bit words produced by the load/XOR register stage and packs four of them into one 16-bit program word. It then drives one ICSP transaction on the target's PGC/PGD pins: a 6-bit command, a fixed delay, then a 16-bit data frame. It sits between the register stage and the programming-header pin drivers.

Parameters:
CLK_DIV, 4, clk_i cycles per PGC half-period (min 1); one bit period = 2*CLK_DIV cycles
GAP_CYC, 4, clk_i cycles between command and data frame, PGC held low (min 1)

Ports:
clk_i  input  1  system clock
assyn_rst_ni  input  1  asynchronous reset, active-low
sync_rst_i  input  1  synchronous reset, active-high, priority over all other inputs
nib_i  input  4  nibble from the register stage
nib_valid_i  input  1  nib_i valid
nib_ready_o  output  1  block accepts nib_i this cycle
cmd_i  input  6  ICSP command, sampled with the 4th nibble
pgc_o  output  1  ICSP clock to target
pgd_o  output  1  ICSP data to target
pgd_oe_o  output  1  PGD output enable
busy_o  output  1  transaction in progress (CMD/GAP/DATA)
done_o  output  1  one-cycle pulse at end of transaction

Behaviour:
- Reset (async low, or sync_rst_i high at clock edge): state=IDLE, nibble count=0, shift regs=0.
- Output values in reset: pgc_o=0, pgd_o=0, pgd_oe_o=0, busy_o=0, done_o=0, nib_ready_o=0 while assyn_rst_ni low.
- Assertion of either reset mid-transaction aborts it immediately. No done_o pulse on abort.
- States: IDLE, COLLECT, CMD, GAP, DATA, DONE.
- Handshake: transfer when nib_valid_i && nib_ready_o at a rising edge.
  - nib_ready_o=1 only in IDLE and COLLECT.
  - nib_valid_i is ignored when nib_ready_o=0.
- Packing order: 1st nibble to word[3:0], 2nd to [7:4], 3rd to [11:8], 4th to [15:12].
  - First transfer: IDLE->COLLECT, count=1.
  - 4th transfer: latch cmd_i, count<=0, ->CMD on the next cycle.
  - No timeout in COLLECT; a partial word waits indefinitely.
- Transmission order: LSB first throughout.
- Bit timing, each bit period is 2*CLK_DIV cycles:
  - First CLK_DIV cycles: pgc_o=1, and pgd_o takes the new bit on the first cycle of the period.
  - Second CLK_DIV cycles: pgc_o=0; the target samples on the falling PGC edge.
  - pgd_o is stable for the whole period.
- CMD: 6 bit periods, cmd[0] first. pgd_oe_o=1.
- GAP: GAP_CYC cycles, pgc_o=0, pgd_o=0, pgd_oe_o=1.
- DATA frame: 16 bit periods, sent as {stop=0, word[13:0], start=0}.
  - Order on the wire: start bit 0, then word[0]..word[13], then stop bit 0.
  - word[15:14] are discarded.
- DONE: one cycle with done_o=1, pgc_o=0, pgd_oe_o=0, then ->IDLE. nib_ready_o=1 again the cycle after DONE.
- busy_o=1 in CMD, GAP and DATA.
- Transaction length from first CMD cycle to DONE: 22*2*CLK_DIV + GAP_CYC cycles (180 at defaults).
- Counters:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - Bit counter counts down; the CMD->GAP and DATA->DONE transitions occur on the last cycle of the final bit period.
  - No off-by-one extra period is allowed.
- pgc_o, pgd_o and pgd_oe_o are driven from registers (glitch-free).

Test Plan:
- Reset: hold assyn_rst_ni=0 for 3 cycles, release -> all outputs 0, nib_ready_o=1 one cycle after release.
- Basic transaction: nibbles F,F,F,3 (word 0x3FFF), cmd_i=6'b000010, default params.
  - PGD per bit period: 0,1,0,0,0,0, then 4 GAP cycles, then 0, fourteen 1s, 0.
  - done_o pulses exactly 180 cycles after entering CMD.
- Packing and discard: nibbles A,5,3,C (word 0xC35A) -> data bits after start: 0,1,0,1,1,0,1,0,1,1,0,0,0,0; word[15:14]=11 not sent.
- Backpressure: hold nib_valid_i=1 with new nibbles throughout the transaction -> nib_ready_o=0 during CMD..DONE, no nibble lost or duplicated; the next word starts collecting after DONE.
- Sync reset: pulse sync_rst_i in DATA bit 7 -> next cycle IDLE, pgc/pgd/oe=0, no done_o.
- Sync reset in COLLECT: pulse sync_rst_i after 2 nibbles -> the following 4 nibbles form a fresh word.
- Parameter sweep: CLK_DIV=1, GAP_CYC=1 -> PGC toggles every cycle, transaction length 45 cycles.

Source files
------------

// File: rtl/icsp_nibble_tx.sv
// ICSP serializer: packs four nibbles into a program word, then clocks out a
// 6-bit command, a fixed gap and a 16-bit data frame on PGC/PGD, LSB first.
module icsp_nibble_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       clk_i,
  input  logic       assyn_rst_ni,
  input  logic       sync_rst_i,
  input  logic [3:0] nib_i,
  input  logic       nib_valid_i,
  output logic       nib_ready_o,
  input  logic [5:0] cmd_i,
  output logic       pgc_o,
  output logic       pgd_o,
  output logic       pgd_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] state_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CMD     = 3'd2,
    GAP     = 3'd3,
    DATA    = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e           state_q, state_n;
  logic [1:0]       cnt_q, cnt_n;
  logic [13:0]      word_q, word_n;
  logic [14:0]      sh_q, sh_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic             half_q, half_n;
  logic [3:0]       bit_q, bit_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic             pgc_q, pgc_n;
  logic             pgd_q, pgd_n;
  logic             oe_q, oe_n;
  logic             rdy_q, rdy_n;
  logic             xfer;
  logic             div_wrap;

  // Handshake: a nibble moves on a rising edge where nib_valid_i && nib_ready_o;
  // nib_ready_o is registered, so it only reflects IDLE/COLLECT once out of reset.
  assign xfer     = nib_valid_i && rdy_q;
  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    word_n  = word_q;
    sh_n    = sh_q;
    div_n   = div_q;
    half_n  = half_q;
    bit_n   = bit_q;
    gap_n   = gap_q;
    pgc_n   = pgc_q;
    pgd_n   = pgd_q;
    oe_n    = oe_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (xfer) begin
          // word[15:14] never reach the wire, so only nib_i[1:0] of the 4th nibble is kept
          case (cnt_q)
            2'd0:    word_n[3:0]   = nib_i;
            2'd1:    word_n[7:4]   = nib_i;
            2'd2:    word_n[11:8]  = nib_i;
            default: word_n[13:12] = nib_i[1:0];
          endcase
          cnt_n = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_n = CMD;
            pgc_n   = 1'b1;
            pgd_n   = cmd_i[0];
            oe_n    = 1'b1;
            sh_n    = {10'b0, cmd_i[5:1]};
            bit_n   = 4'd5;
            div_n   = '0;
            half_n  = 1'b0;
          end else begin
            state_n = COLLECT;
          end
        end
      end
      CMD, DATA: begin
        if (div_wrap) begin
          div_n = '0;
          if (!half_q) begin
            half_n = 1'b1;
            pgc_n  = 1'b0;
          end else if (bit_q != 4'd0) begin
            half_n = 1'b0;
            pgc_n  = 1'b1;
            pgd_n  = sh_q[0];
            sh_n   = {1'b0, sh_q[14:1]};
            bit_n  = bit_q - 4'd1;
          end else if (state_q == CMD) begin
            state_n = GAP;
            pgd_n   = 1'b0;
            gap_n   = '0;
          end else begin
            state_n = DONE;
            pgd_n   = 1'b0;
            oe_n    = 1'b0;
          end
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          // start bit goes out now; the remaining 15 frame bits are {stop, word[13:0]}
          state_n = DATA;
          pgc_n   = 1'b1;
          pgd_n   = 1'b0;
          sh_n    = {1'b0, word_q};
          bit_n   = 4'd15;
          div_n   = '0;
          half_n  = 1'b0;
        end else begin
          gap_n = gap_q + GAP_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    rdy_n = (state_n == IDLE) || (state_n == COLLECT);
  end

  always_ff @(posedge clk_i or negedge assyn_rst_ni) begin
    if (!assyn_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      pgc_q   <= 1'b0;
      pgd_q   <= 1'b0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else if (sync_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      pgc_q   <= 1'b0;
      pgd_q   <= 1'b0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      word_q  <= word_n;
      sh_q    <= sh_n;
      div_q   <= div_n;
      half_q  <= half_n;
      bit_q   <= bit_n;
      gap_q   <= gap_n;
      pgc_q   <= pgc_n;
      pgd_q   <= pgd_n;
      oe_q    <= oe_n;
      rdy_q   <= rdy_n;
    end
  end

  assign nib_ready_o = rdy_q;
  assign pgc_o       = pgc_q;
  assign pgd_o       = pgd_q;
  assign pgd_oe_o    = oe_q;
  assign busy_o      = (state_q == CMD) || (state_q == GAP) || (state_q == DATA);
  assign done_o      = (state_q == DONE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_icsp_nibble_tx.sv
// Directed bench for icsp_nibble_tx: default-parameter instance plus a
// CLK_DIV=1 / GAP_CYC=1 instance, checked cycle by cycle against hand-built frames.
module tb_icsp_nibble_tx;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       srst0, srst1;
  logic [3:0] nib0, nib1;
  logic       v0, v1;
  logic [5:0] cmd0, cmd1;
  logic       rdy0, pgc0, pgd0, oe0, busy0, done0;
  logic       rdy1, pgc1, pgd1, oe1, busy1, done1;
  logic [2:0] st0, st1;

  icsp_nibble_tx dut0 (
    .clk_i(clk), .assyn_rst_ni(rst_n), .sync_rst_i(srst0),
    .nib_i(nib0), .nib_valid_i(v0), .nib_ready_o(rdy0), .cmd_i(cmd0),
    .pgc_o(pgc0), .pgd_o(pgd0), .pgd_oe_o(oe0),
    .busy_o(busy0), .done_o(done0), .state_o(st0)
  );

  icsp_nibble_tx #(.CLK_DIV(1), .GAP_CYC(1)) dut1 (
    .clk_i(clk), .assyn_rst_ni(rst_n), .sync_rst_i(srst1),
    .nib_i(nib1), .nib_valid_i(v1), .nib_ready_o(rdy1), .cmd_i(cmd1),
    .pgc_o(pgc1), .pgd_o(pgd1), .pgd_oe_o(oe1),
    .busy_o(busy1), .done_o(done1), .state_o(st1)
  );

  // selected instance for the shared driver/checker tasks
  logic       sel;
  logic       rdy_s, pgc_s, pgd_s, oe_s, busy_s, done_s;
  logic [2:0] st_s;
  assign rdy_s  = sel ? rdy1  : rdy0;
  assign pgc_s  = sel ? pgc1  : pgc0;
  assign pgd_s  = sel ? pgd1  : pgd0;
  assign oe_s   = sel ? oe1   : oe0;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign st_s   = sel ? st1   : st0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_in(input logic [3:0] n, input logic v);
    if (sel) begin
      nib1 = n;
      v1   = v;
    end else begin
      nib0 = n;
      v0   = v;
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    int cnt = 0;
    set_in(n, 1'b1);
    while (rdy_s !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    check("nib_ready", {31'b0, rdy_s}, 32'd1);
    tick();
    set_in(n, 1'b0);
  endtask

  // Expected wire activity from the first CMD cycle up to and including DONE,
  // then one IDLE cycle. Vector is {pgc, pgd, oe, busy, done, ready}.
  task automatic check_frame(input int d, input int g, input logic [5:0] cmd,
                             input logic [15:0] frame, input string tag);
    int len = 44 * d + g;
    int u;
    logic [5:0] exp_v;
    logic [5:0] obs_v;
    for (int t = 0; t <= len; t++) begin
      if (t < 12 * d) begin
        exp_v = {((t % (2 * d)) < d), cmd[t / (2 * d)], 1'b1, 1'b1, 1'b0, 1'b0};
      end else if (t < 12 * d + g) begin
        exp_v = 6'b001100;
      end else if (t < len) begin
        u = t - 12 * d - g;
        exp_v = {((u % (2 * d)) < d), frame[u / (2 * d)], 1'b1, 1'b1, 1'b0, 1'b0};
      end else begin
        exp_v = 6'b000010;
      end
      obs_v = {pgc_s, pgd_s, oe_s, busy_s, done_s, rdy_s};
      check($sformatf("%s_t%0d", tag, t), {26'b0, obs_v}, {26'b0, exp_v});
      tick();
    end
    check($sformatf("%s_after_done", tag), {27'b0, st_s, rdy_s, done_s}, {27'b0, 3'd0, 1'b1, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel   = 1'b0;
    rst_n = 1'b0;
    srst0 = 1'b0;
    srst1 = 1'b0;
    nib0  = 4'h0;
    nib1  = 4'h0;
    v0    = 1'b0;
    v1    = 1'b0;
    cmd0  = 6'b0;
    cmd1  = 6'b0;

    // reset held for 3 cycles: every output low
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs0", {26'b0, pgc0, pgd0, oe0, busy0, done0, rdy0}, 32'd0);
    check("rst_outs1", {26'b0, pgc1, pgd1, oe1, busy1, done1, rdy1}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", {31'b0, rdy0}, 32'd0);
    tick();
    check("rel_ready0", {27'b0, rdy0, pgc0, pgd0, oe0, busy0}, {27'b0, 5'b10000});
    check("rel_ready1", {27'b0, rdy1, pgc1, pgd1, oe1, busy1}, {27'b0, 5'b10000});

    // basic: word 0x3FFF, cmd 000010 -> frame {0, 14'h3FFF, 0}
    cmd0 = 6'b000010;
    send_nib(4'hF);
    send_nib(4'hF);
    send_nib(4'hF);
    send_nib(4'h3);
    check_frame(4, 4, 6'b000010, 16'h7FFE, "basic");

    // packing: A,5,3,C -> word 0xC35A, bits [15:14] dropped
    cmd0 = 6'b110011;
    send_nib(4'hA);
    send_nib(4'h5);
    send_nib(4'h3);
    send_nib(4'hC);
    check_frame(4, 4, 6'b110011, 16'h06B4, "pack");

    // backpressure: next nibble held valid across the whole transaction
    cmd0 = 6'b101101;
    send_nib(4'h1);
    send_nib(4'h2);
    send_nib(4'h4);
    send_nib(4'h8);
    cmd0 = 6'b011110;
    set_in(4'h6, 1'b1);
    check_frame(4, 4, 6'b101101, 16'h0842, "bp1");
    send_nib(4'h6);
    send_nib(4'h9);
    send_nib(4'h0);
    send_nib(4'h7);
    check_frame(4, 4, 6'b011110, 16'h612C, "bp2");

    // sync reset during DATA bit 7 (frame 0x0786, bit 7 = 1)
    cmd0 = 6'b000001;
    send_nib(4'h3);
    send_nib(4'hC);
    send_nib(4'h3);
    send_nib(4'hC);
    for (int t = 0; t < 108; t++) tick();
    check("data_bit7", {30'b0, pgc0, pgd0}, {30'b0, 2'b11});
    tick();
    tick();
    srst0 = 1'b1;
    tick();
    srst0 = 1'b0;
    check("srst_data", {26'b0, st0, pgc0, pgd0, oe0}, 32'd0);
    check("srst_flags", {30'b0, busy0, done0}, 32'd0);
    for (int t = 0; t < 6; t++) begin
      tick();
      check($sformatf("srst_no_done_%0d", t), {29'b0, st0}, 32'd0);
      check($sformatf("srst_quiet_%0d", t), {28'b0, pgc0, oe0, busy0, done0}, 32'd0);
    end

    // sync reset in COLLECT after 2 nibbles: the next 4 form a fresh word 0x1E69
    send_nib(4'h7);
    send_nib(4'h7);
    srst0 = 1'b1;
    tick();
    srst0 = 1'b0;
    check("srst_col_state", {29'b0, st0}, 32'd0);
    cmd0 = 6'b111000;
    send_nib(4'h9);
    send_nib(4'h6);
    send_nib(4'hE);
    send_nib(4'h1);
    check_frame(4, 4, 6'b111000, 16'h3CD2, "srst_col");

    // CLK_DIV=1, GAP_CYC=1: PGC toggles every cycle, 45-cycle transaction
    sel  = 1'b1;
    cmd1 = 6'b010101;
    send_nib(4'h5);
    send_nib(4'hA);
    send_nib(4'h5);
    send_nib(4'hA);
    check_frame(1, 1, 6'b010101, 16'h4B4A, "sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
